// File: rtl/fib_mem_checker_if.sv
// Request, memory-read and result signals of the Fibonacci memory checker.
// The master side is the requester plus data memory; the slave side is the checker.
`timescale 1ns/1ps
interface fib_mem_checker_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = 64
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] seed0;
    logic [DATA_W-1:0] seed1;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              overflow;
    logic [LEN_W-1:0]  mismatch_cnt;
    logic [ADDR_W-1:0] first_bad_addr;
    logic [DATA_W-1:0] first_bad_exp;
    logic [DATA_W-1:0] first_bad_got;

    modport master (
        output start, len, seed0, seed1, rd_data,
        input  rd_en, rd_addr, busy, done, pass, overflow, mismatch_cnt,
        input  first_bad_addr, first_bad_exp, first_bad_got
    );

    modport slave (
        input  start, len, seed0, seed1, rd_data,
        output rd_en, rd_addr, busy, done, pass, overflow, mismatch_cnt,
        output first_bad_addr, first_bad_exp, first_bad_got
    );
endinterface

// File: rtl/fib_mem_checker.sv
// Regenerates a generalised Fibonacci sequence and checks it word by word against
// a synchronous-read data memory, reporting pass, mismatch count and first bad word.
`timescale 1ns/1ps
module fib_mem_checker #(
    parameter int              DATA_W       = 32,
    parameter int              ADDR_W       = 32,
    parameter int              MAX_LEN      = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter bit              STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    fib_mem_checker_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_CMP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              a_wrap_q, a_wrap_d, b_wrap_q, b_wrap_d;
    logic [LEN_W-1:0]  idx_q, idx_d, len_q, len_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, ovf_q, ovf_d;
    logic [LEN_W-1:0]  mm_q, mm_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_exp_q, fb_exp_d, fb_got_q, fb_got_d;

    logic [DATA_W:0]   sum_s;
    logic              mismatch_s;
    logic [LEN_W-1:0]  len_clamp_s;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [LEN_W-1:0] i);
        return BASE_ADDR + ADDR_W'({i, 2'b00});
    endfunction

    // Next-state and next-output computation for the IDLE/READ/CMP/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        a_wrap_d  = a_wrap_q;
        b_wrap_d  = b_wrap_q;
        idx_d     = idx_q;
        len_d     = len_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        ovf_d     = ovf_q;
        mm_d      = mm_q;
        fb_addr_d = fb_addr_q;
        fb_exp_d  = fb_exp_q;
        fb_got_d  = fb_got_q;

        sum_s       = {1'b0, a_q} + {1'b0, b_q};
        mismatch_s  = (bus.rd_data != a_q);
        len_clamp_s = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d       = bus.seed0;
                    b_d       = bus.seed1;
                    a_wrap_d  = 1'b0;
                    b_wrap_d  = 1'b0;
                    idx_d     = '0;
                    len_d     = len_clamp_s;
                    mm_d      = '0;
                    ovf_d     = 1'b0;
                    fb_addr_d = '0;
                    fb_exp_d  = '0;
                    fb_got_d  = '0;
                    if (len_clamp_s == '0) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        busy_d    = 1'b1;
                        pass_d    = 1'b0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = word_addr('0);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                if (mismatch_s) begin
                    if (mm_q != {LEN_W{1'b1}}) begin
                        mm_d = mm_q + LEN_W'(1);
                    end else begin
                        mm_d = mm_q;
                    end
                    if (mm_q == '0) begin
                        fb_addr_d = word_addr(idx_q);
                        fb_exp_d  = a_q;
                        fb_got_d  = bus.rd_data;
                    end else begin
                        fb_addr_d = fb_addr_q;
                    end
                end else begin
                    mm_d = mm_q;
                end
                if (a_wrap_q) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
                // Wrap flags follow their terms so overflow reflects only checked words.
                a_d      = b_q;
                b_d      = sum_s[DATA_W-1:0];
                a_wrap_d = b_wrap_q;
                b_wrap_d = sum_s[DATA_W] | a_wrap_q | b_wrap_q;
                idx_d    = idx_q + LEN_W'(1);
                if ((idx_d == len_q) || (STOP_ON_FAIL && mismatch_s)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mm_d == '0);
                end else begin
                    state_d   = ST_READ;
                    rd_en_d   = 1'b1;
                    rd_addr_d = word_addr(idx_d);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            a_wrap_q  <= 1'b0;
            b_wrap_q  <= 1'b0;
            idx_q     <= '0;
            len_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mm_q      <= '0;
            fb_addr_q <= '0;
            fb_exp_q  <= '0;
            fb_got_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_wrap_q  <= a_wrap_d;
            b_wrap_q  <= b_wrap_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            ovf_q     <= ovf_d;
            mm_q      <= mm_d;
            fb_addr_q <= fb_addr_d;
            fb_exp_q  <= fb_exp_d;
            fb_got_q  <= fb_got_d;
        end
    end

    assign bus.rd_en          = rd_en_q;
    assign bus.rd_addr        = rd_addr_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.overflow       = ovf_q;
    assign bus.mismatch_cnt   = mm_q;
    assign bus.first_bad_addr = fb_addr_q;
    assign bus.first_bad_exp  = fb_exp_q;
    assign bus.first_bad_got  = fb_got_q;
endmodule
